// File: rtl/alu_src_ctrl.sv
// alu_src_ctrl: control FSM for a multicycle datapath (fetch / decode / execute /
// memory / write-back). Outputs are decoded combinationally from the current
// state, zero and mem_ready.
// Build option: define ALU_SRC_CTRL_BNE_EN to execute bne (opcode 000101) through
// the BRANCH state. Without it, that opcode is reported as illegal.
module alu_src_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ALUOutWrite,
  output logic       PCWrite,
  output logic       PCSource,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    WB_R   = 4'd3,
    EXEC_I = 4'd4,
    WB_I   = 4'd5,
    ADDR   = 4'd6,
    MEM    = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef ALU_SRC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  state_t state_reg;
  state_t state_next;
  logic   branch_taken;

  // Branch condition: beq takes on zero, bne (when built in) on not-zero.
  always_comb begin
    branch_taken = zero;
`ifdef ALU_SRC_CTRL_BNE_EN
    if (opcode == OP_BNE) begin
      branch_taken = ~zero;
    end
`endif
  end

  // State register; reset returns to FETCH, abandoning any instruction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and output decode; write enables are suppressed while reset is low.
  always_comb begin
    state_next  = state_reg;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALU_IDLE;
    ALUOutWrite = 1'b0;
    PCWrite     = 1'b0;
    PCSource    = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    illegal     = 1'b0;

    case (state_reg)
      FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          // Latch the instruction and advance PC by 4 in the same cycle.
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          ALUSrcB    = SRCB_FOUR;
          ALUOp      = ALU_ADD;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Precompute the branch target into ALUOut regardless of opcode.
        ALUSrcB     = SRCB_IMM_SH2;
        ALUOp       = ALU_ADD;
        ALUOutWrite = 1'b1;
        case (opcode)
          OP_RTYPE:     state_next = EXEC_R;
          OP_ADDI:      state_next = EXEC_I;
          OP_LW, OP_SW: state_next = ADDR;
          OP_BEQ:       state_next = BRANCH;
`ifdef ALU_SRC_CTRL_BNE_EN
          OP_BNE:       state_next = BRANCH;
`endif
          default: begin
            illegal    = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        ALUSrcA     = 1'b1;
        ALUOutWrite = 1'b1;
        state_next  = WB_R;
        case (funct)
          FN_ADD: ALUOp = ALU_ADD;
          FN_SUB: ALUOp = ALU_SUB;
          FN_AND: ALUOp = ALU_AND;
          default: begin
            ALUOutWrite = 1'b0;
            illegal     = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      WB_R: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        state_next = FETCH;
      end
      EXEC_I, ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALUOp       = ALU_ADD;
        ALUOutWrite = 1'b1;
        state_next  = (state_reg == ADDR) ? MEM : WB_I;
      end
      WB_I: begin
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      MEM: begin
        // Hold the request until the memory handshakes.
        IorD = 1'b1;
        if (opcode == OP_SW) begin
          MemWrite = 1'b1;
        end else begin
          MemRead = 1'b1;
        end
        if (mem_ready) begin
          state_next = (opcode == OP_SW) ? FETCH : WB_MEM;
        end
      end
      WB_MEM: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_SUB;
        PCWrite    = branch_taken;
        PCSource   = branch_taken;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    if (!reset) begin
      ALUOutWrite = 1'b0;
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      illegal     = 1'b0;
    end
  end

  assign state = state_reg;

endmodule
